// File: rtl/mystery_pack_fifo.sv
// Mode-selected field packer feeding a DEPTH-entry valid/ready FIFO.
// Optional stored even parity on the head entry: define MYSTERY_PACK_PARITY_EN.
module mystery_pack_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               a,
    input  logic [W-1:0]             b,
    input  logic [W-1:0]             c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
`ifdef MYSTERY_PACK_PARITY_EN
    output logic                     out_parity,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned FW = (W - 2) / 2;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
`ifdef MYSTERY_PACK_PARITY_EN
    localparam int unsigned EW = W + 1;
`else
    localparam int unsigned EW = W;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [W-1:0]  packed_c;
    logic [EW-1:0] entry_c;
    logic [EW-1:0] head_c;
    logic          full_c;
    logic          empty_c;
    logic          push_c;
    logic          pop_c;

    // Field packing applied to the operands at push time
    always_comb begin
        packed_c = b;
        case (a)
            2'd0:    packed_c = {2'b00, b[FW-1:0], c[FW-1:0]};
            2'd1:    packed_c = {2'b01, c[FW-1:0], b[FW-1:0]};
            2'd2:    packed_c = b;
            default: packed_c = c;
        endcase
    end

`ifdef MYSTERY_PACK_PARITY_EN
    assign entry_c = {^packed_c, packed_c};
`else
    assign entry_c = packed_c;
`endif

    // Wrap bit distinguishes full from empty when the low pointer bits match
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_ready  = !full_c;
    assign out_valid = !empty_c;
    assign occupancy = count;

    // Flush wins over any same-cycle handshake; the pushed beat is dropped
    assign push_c = in_valid && !full_c && !flush;
    assign pop_c  = out_ready && !empty_c && !flush;

    assign head_c   = mem[rd_ptr[AW-1:0]];
    assign out_data = out_valid ? head_c[W-1:0] : '0;

`ifdef MYSTERY_PACK_PARITY_EN
    assign out_parity = out_valid && !reset && head_c[W];
`endif

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + PW'(push_c) - PW'(pop_c);
        end
    end

    // Storage needs no reset: contents are masked until a push makes them valid
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr[AW-1:0]] <= entry_c;
    end

endmodule

// File: tb/tb_mystery_pack_fifo.sv
// Self-checking bench for mystery_pack_fifo (W=8, DEPTH=4) with a queue scoreboard.
// Define MYSTERY_PACK_PARITY_EN to also cover the parity output.
module tb_mystery_pack_fifo;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] occupancy;
`ifdef MYSTERY_PACK_PARITY_EN
    logic       out_parity;
`endif

    mystery_pack_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef MYSTERY_PACK_PARITY_EN
        .out_parity(out_parity),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] sb [$];
    int         checks = 0;
    int         errors = 0;
    logic       last_push;

    function automatic logic [7:0] model_pack(logic [1:0] m, logic [7:0] bb, logic [7:0] cc);
        case (m)
            2'd0:    return 8'(int'(bb % 8) * 8 + int'(cc % 8));
            2'd1:    return 8'(64 + int'(cc % 8) * 8 + int'(bb % 8));
            2'd2:    return bb;
            default: return cc;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [1:0] m, logic [7:0] bb, logic [7:0] cc);
        in_valid = v;
        a = m;
        b = bb;
        c = cc;
    endtask

    // One clock: compare against the scoreboard at negedge, then commit the model
    task automatic cycle();
        bit do_push;
        bit do_pop;
        @(negedge clk);
        check("occupancy", 32'(occupancy), 32'(sb.size()));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
        if (sb.size() != 0) check("out_data", 32'(out_data), 32'(sb[0]));
        else                check("out_data_idle", 32'(out_data), 32'd0);
`ifdef MYSTERY_PACK_PARITY_EN
        if (sb.size() != 0 && !reset) check("out_parity", 32'(out_parity), 32'(^sb[0]));
        else                          check("out_parity_idle", 32'(out_parity), 32'd0);
`endif
        do_push   = in_valid && (sb.size() != DEPTH);
        do_pop    = out_ready && (sb.size() != 0);
        last_push = 1'b0;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(model_pack(a, b, c));
            last_push = do_push;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int budget);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{a: 2'd0, b: 8'h05, c: 8'h03, exp: 8'h2B};
        vecs[1] = '{a: 2'd1, b: 8'h05, c: 8'h03, exp: 8'h5D};
        vecs[2] = '{a: 2'd2, b: 8'hA5, c: 8'h03, exp: 8'hA5};
        vecs[3] = '{a: 2'd3, b: 8'hA5, c: 8'h3C, exp: 8'h3C};

        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        last_push = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: each mode, visible exactly one cycle after the push
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
            check("mode_not_early", 32'(out_valid), 32'd0);
            cycle();
            drive(1'b0, 2'd0, 8'h00, 8'h00);
            check("mode_valid", 32'(out_valid), 32'd1);
            check("mode_data", 32'(out_data), 32'(vecs[i].exp));
            out_ready = 1'b1;
            cycle();
        end

        // 2: fill with consumer stalled; fifth beat held until drain
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 8'h10 + 8'(k), 8'h20 + 8'(k));
            cycle();
        end
        drive(1'b1, 2'd2, 8'h99, 8'h00);
        check("full_occupancy", 32'(occupancy), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) cycle();
        check("held_head", 32'(out_data), 32'(model_pack(2'd0, 8'h10, 8'h20)));
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (in_valid && n < 10) begin
                cycle();
                if (last_push) in_valid = 1'b0;
                n++;
            end
            check("fifth_beat_accepted", 32'(in_valid), 32'd0);
        end
        drain(10);

        // 3: steady push+pop at occupancy 2 across pointer wrap
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'd3, 8'h00, 8'hC0 + 8'(k));
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 2'($urandom_range(3)), 8'($urandom), 8'($urandom));
            cycle();
            check("steady_occupancy", 32'(occupancy), 32'd2);
        end
        drain(10);

        // 4: flush at occupancy 3 drops the concurrent push
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd2, 8'h50 + 8'(k), 8'h00);
            cycle();
        end
        flush = 1'b1;
        drive(1'b1, 2'd2, 8'h77, 8'h00);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        cycle();
        flush = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_data", 32'(out_data), 32'd0);
        cycle();

        // 5: reset while full and presenting data
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd3, 8'h00, 8'hE0 + 8'(k));
            cycle();
        end
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        out_ready = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset_occupancy", 32'(occupancy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        cycle();

`ifdef MYSTERY_PACK_PARITY_EN
        // 6: stored parity of the head entry
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 8'h05, 8'h03);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        check("parity_even", 32'(out_parity), 32'd0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        drive(1'b1, 2'd2, 8'h01, 8'h00);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        check("parity_odd", 32'(out_parity), 32'd1);
        drain(4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
